// File: rtl/uart_pkg.sv
// Shared UART state encodings and frame constants.
// Build with PARITY_EN defined for 8E1 frames (adds R_PARITY).
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_PARITY,
    R_STOP
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;
`endif

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_STROBE
  } wr_state_t;

endpackage

// File: rtl/rx_sampler.sv
// rx synchroniser plus bit-time down-counter.
// sample_tick is high while running and the counter is at zero.
module rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2,
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          run,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          rxs,
  output logic          sample_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      if (load)
        r_cnt <= load_val;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign rxs         = r_sync[SYNC_STAGES-1];
  assign sample_tick = run && (r_cnt == '0);

endmodule

// File: rtl/com_to_fifo.sv
// UART receiver feeding the shared FIFO via busy/write-strobe.
// PARITY_EN selects 8E1 framing and adds the parity_err port.
module com_to_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  input  logic       fifo_busy,
  input  logic       fifo_full,
  input  logic       err_clr,
  output logic [7:0] fifo_data_in,
  output logic       fifo_we,
  output logic       rx_done,
  output logic       frame_err,
`ifdef PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

  rx_state_t r_rst;
  wr_state_t r_wst;
  logic [7:0] r_shift, r_hold, r_data;
  logic [2:0] r_idx;
  logic r_we, r_done, r_frame, r_ovr;

  logic w_rxs, w_tick, w_stk, w_idle;
  logic w_cnt_ld, w_good, w_load;
  logic w_frame_set, w_ovr_rx, w_ovr_wr;

  assign w_idle   = (r_rst == R_IDLE);
  assign w_cnt_ld = (w_idle && !w_rxs) || w_tick;

  rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_smp (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .run        (!w_idle),
    .load       (w_cnt_ld),
    .load_val   (w_idle ? HALF : FULL),
    .rxs        (w_rxs),
    .sample_tick(w_tick)
  );

  assign w_stk       = enable && w_tick && (r_rst == R_STOP);
  assign w_frame_set = w_stk && !w_rxs;

`ifdef PARITY_EN
  logic r_pbad, r_perr, w_par_set;
  assign w_par_set = enable && w_tick && (r_rst == R_PARITY)
                     && (^{r_shift, w_rxs});
  assign w_good    = w_stk && w_rxs && !r_pbad;
  assign parity_err = r_perr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pbad <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_idle)
        r_pbad <= 1'b0;
      else if (w_par_set)
        r_pbad <= 1'b1;
      r_perr <= w_par_set | (r_perr & ~err_clr);
    end
  end
`else
  assign w_good = w_stk && w_rxs;
`endif

  assign w_load   = w_good && (r_wst == W_IDLE);
  assign w_ovr_rx = w_good && (r_wst != W_IDLE);
  assign w_ovr_wr = (r_wst == W_WAIT) && !fifo_busy && fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst   <= R_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
    end else if (!enable) begin
      r_rst <= R_IDLE;
    end else begin
      case (r_rst)
        R_IDLE: begin
          r_idx <= '0;
          if (!w_rxs) r_rst <= R_START;
        end
        R_START:
          if (w_tick) r_rst <= w_rxs ? R_IDLE : R_DATA;
        R_DATA:
          if (w_tick) begin
            r_shift[r_idx] <= w_rxs;
            r_idx          <= r_idx + 1'b1;
`ifdef PARITY_EN
            if (r_idx == LAST) r_rst <= R_PARITY;
`else
            if (r_idx == LAST) r_rst <= R_STOP;
`endif
          end
`ifdef PARITY_EN
        R_PARITY:
          if (w_tick) r_rst <= R_STOP;
`endif
        R_STOP:
          if (w_tick) r_rst <= R_IDLE;
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  // fifo_we/rx_done rise on the edge that leaves W_WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wst  <= W_IDLE;
      r_hold <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_wst)
        W_IDLE:
          if (w_load) begin
            r_hold <= r_shift;
            r_wst  <= W_WAIT;
          end
        W_WAIT:
          if (!fifo_busy) begin
            r_data <= r_hold;
            r_we   <= !fifo_full;
            r_done <= !fifo_full;
            r_wst  <= W_STROBE;
          end
        W_STROBE: r_wst <= W_IDLE;
        default:  r_wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_frame <= w_frame_set | (r_frame & ~err_clr);
      r_ovr   <= w_ovr_rx | w_ovr_wr | (r_ovr & ~err_clr);
    end
  end

  assign fifo_data_in = r_data;
  assign fifo_we      = r_we;
  assign rx_done      = r_done;
  assign frame_err    = r_frame;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_com_to_fifo.sv
// Directed bench for com_to_fifo: table of frames plus corner sequences.
// Define PARITY_EN to also exercise the 8E1 parity checks.
module tb_com_to_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       rx = 1'b1;
  logic       fifo_busy = 1'b0;
  logic       fifo_full = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] fifo_data_in;
  logic       fifo_we, rx_done, frame_err, overrun;
`ifdef PARITY_EN
  logic       parity_err;
`endif

  com_to_fifo #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rx          (rx),
    .fifo_busy   (fifo_busy),
    .fifo_full   (fifo_full),
    .err_clr     (err_clr),
    .fifo_data_in(fifo_data_in),
    .fifo_we     (fifo_we),
    .rx_done     (rx_done),
    .frame_err   (frame_err),
`ifdef PARITY_EN
    .parity_err  (parity_err),
`endif
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [7:0] exp_last = 8'h00;

  always @(negedge clk) begin
    if (fifo_we) we_cnt++;
    if (rx_done) done_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_we;
    logic       exp_fe;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stopb);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; tick(CPB);
    end
`ifdef PARITY_EN
    rx = ^d; tick(CPB);
`endif
    rx = stopb; tick(CPB);
    rx = 1'b1; tick(4);
  endtask

`ifdef PARITY_EN
  task automatic send_par(input logic [7:0] d, input logic pb);
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; tick(CPB);
    end
    rx = pb; tick(CPB);
    rx = 1'b1; tick(CPB + 4);
  endtask
`endif

  task automatic clear_cnt();
    we_cnt = 0;
    done_cnt = 0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h41, 1'b1, 1, 1'b0};
    vecs[1] = '{8'hC3, 1'b0, 0, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1, 1'b0};
    vecs[5] = '{8'h81, 1'b0, 0, 1'b1};

    tick(3);
    check("rst_data", fifo_data_in, 0);
    check("rst_we", fifo_we, 0);
    check("rst_done", rx_done, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b1;
    enable = 1'b1;
    tick(5);

    foreach (vecs[k]) begin
      clear_cnt();
      send(vecs[k].data, vecs[k].stop);
      tick(CPB);
      if (vecs[k].exp_we != 0) exp_last = vecs[k].data;
      check($sformatf("v%0d_we", k), we_cnt, vecs[k].exp_we);
      check($sformatf("v%0d_done", k), done_cnt, vecs[k].exp_we);
      check($sformatf("v%0d_data", k), fifo_data_in, exp_last);
      check($sformatf("v%0d_fe", k), frame_err, vecs[k].exp_fe);
      check($sformatf("v%0d_ovr", k), overrun, 0);
      if (vecs[k].exp_fe) begin
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        check($sformatf("v%0d_clr", k), frame_err, 0);
      end
    end

    // start glitch: low for 4 cycles only
    clear_cnt();
    rx = 1'b0; tick(4); rx = 1'b1; tick(3 * CPB);
    check("glitch_we", we_cnt, 0);
    check("glitch_fe", frame_err, 0);
    clear_cnt();
    send(8'h3C, 1'b1);
    tick(CPB);
    check("post_glitch_we", we_cnt, 1);
    check("post_glitch_data", fifo_data_in, 8'h3C);

    // enable dropped mid-frame
    clear_cnt();
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(CPB);
    enable = 1'b0;
    rx = 1'b0; tick(3 * CPB);
    rx = 1'b1; tick(2 * CPB);
    enable = 1'b1;
    tick(12 * CPB);
    check("abort_we", we_cnt, 0);
    check("abort_fe", frame_err, 0);

    // busy held across two frames
    clear_cnt();
    fifo_busy = 1'b1;
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    tick(CPB);
    check("busy_no_we", we_cnt, 0);
    check("busy_ovr", overrun, 1);
    fifo_busy = 1'b0;
    tick(CPB);
    check("busy_we", we_cnt, 1);
    check("busy_done", done_cnt, 1);
    check("busy_data", fifo_data_in, 8'h55);

    // async reset during data bit 3 of 0x12
    clear_cnt();
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h12 >> i); tick(CPB);
    end
    rx = 1'b0; tick(CPB / 2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_data", fifo_data_in, 0);
    check("mid_rst_we", fifo_we, 0);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_fe", frame_err, 0);
    rx = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(12 * CPB);
    check("mid_rst_nowr", we_cnt, 0);
    send(8'h7E, 1'b1);
    tick(CPB);
    check("rst_7e_we", we_cnt, 1);
    check("rst_7e_data", fifo_data_in, 8'h7E);

    // fifo full: byte dropped, overrun set
    clear_cnt();
    fifo_full = 1'b1;
    send(8'h99, 1'b1);
    tick(CPB);
    fifo_full = 1'b0;
    check("full_we", we_cnt, 0);
    check("full_ovr", overrun, 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    check("ovr_clr", overrun, 0);

`ifdef PARITY_EN
    clear_cnt();
    send_par(8'h41, 1'b1);
    check("par_bad_we", we_cnt, 0);
    check("par_err", parity_err, 1);
    clear_cnt();
    send_par(8'h41, 1'b0);
    check("par_ok_we", we_cnt, 1);
    check("par_ok_data", fifo_data_in, 8'h41);
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    check("par_clr", parity_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
